sort_ascending_5: RTL and testbench
===================================

// Module: sort_ascending_5
// PURPOSE
//  Pipelined 5-input ascending sorter for the 5x5 median filter datapath.
//  Sorts one 5-sample column (or row) per clock and outputs all five ranks.
//  Valid flag travels alongside the data. Downstream median logic uses min/out2/mid/out4/max.
// PARAMETERS
//  DATA_WIDTH  8  bit width of every sample and every sorted output (unsigned)
// PORTS
//  clk     in   1           rising-edge clock; only clock
//  rst     in   1           asynchronous, active-high reset
//  done_i  in   1           input valid; S1..S5 sampled on clk when high
//  S1..S5  in   DATA_WIDTH  unsorted unsigned samples, five separate ports
//  done_o  out  1           output valid; done_i delayed by exactly 5 cycles
//  min     out  DATA_WIDTH  smallest sample
//  out2    out  DATA_WIDTH  2nd smallest
//  mid     out  DATA_WIDTH  median (3rd)
//  out4    out  DATA_WIDTH  2nd largest
//  max     out  DATA_WIDTH  largest
// BEHAVIOUR
//  - Network: optimal 9-comparator, depth-5 sorting network. Index 0..4 = S1..S5.
//    L1 (0,3)(1,4) | L2 (0,2)(1,3) | L3 (0,1)(2,4) | L4 (1,2)(3,4) | L5 (2,3).
//    Each compare-swap (a,b): lo->a, hi->b, unsigned compare; on tie no swap.
//  - One register bank after each layer. Latency = 5 clocks, fully pipelined.
//    Throughput is 1 set/clock, no stall, no backpressure.
//  - Inputs captured at edge N appear on outputs after edge N+4, i.e. 5 edges including capture.
//    done_o = done_i 5 cycles earlier via 5-bit valid shift register.
//  - Outputs are registered; min<=out2<=mid<=out4<=max whenever done_o=1.
//  - Back-to-back valid sets produce back-to-back done_o pulses in input order.
//  - Equal values: output multiset equals input multiset, no value loss or duplication.
//  - Extremes 0 and 2^DATA_WIDTH-1 need no special handling, no overflow path.
//  - Reset (async assert, sync release): all data regs, all outputs and the valid pipe
//    go to 0. Reset mid-stream discards all in-flight sets; no done_o until
//    5 cycles after the first done_i following release.
//  - Values on outputs while done_o=0 are don't-care unless SORT5_HOLD_EN is set.
// CONFIGURATION
//  SORT5_HOLD_EN undefined: data stage registers load every cycle (free-running).
//    Outputs track whatever flows through, even invalid data.
//  SORT5_HOLD_EN defined: each stage's data registers load only when that stage's
//    valid bit is set. Outputs hold the last valid sorted set while done_o=0.
//    Lower toggle power. Latency and done_o timing are unchanged.
// STRUCTURE
//  - Shared package sort_pkg: DATA_WIDTH default constant, SORT5_LATENCY=5,
//    typedef sample_t [DATA_WIDTH-1:0].
//  - Sub-module cas_unit (combinational compare-swap: a,b -> lo,hi), instantiated 9x.
//  - Top: 5 layer register banks plus valid shift register; no FSM.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> all outputs 0, done_o=0.
//  2 S=12,24,35,9,18, done_i=1 one cycle -> 5 cycles later done_o=1 for 1 cycle,
//    min..max = 9,12,18,24,35.
//  3 Back-to-back: case 2 then S=50,40,30,20,10 next cycle -> consecutive done_o;
//    second output 10,20,30,40,50.
//  4 Ties/extremes: S=255,0,255,0,128 -> 0,0,128,255,255. S=7x5 -> all 7.
//  5 Reset mid-stream: 3 valid sets, rst pulsed 2 cycles later -> no done_o from
//    those sets; new set after release appears 5 cycles later, correct.
//  6 Random 1000 sets with random done_i gaps vs reference model: sorted match,
//    done_o count = done_i count. With SORT5_HOLD_EN, outputs constant while done_o=0.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared constants and sample type for the 5-input ascending sorter.
package sort_pkg;

  localparam int SORT5_DATA_WIDTH = 8;
  localparam int SORT5_LATENCY    = 5;

  typedef logic [SORT5_DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/cas_unit.sv
// Combinational unsigned compare-swap: smaller value on lo, larger on hi; ties pass straight through.
module cas_unit #(
  parameter int W = sort_pkg::SORT5_DATA_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic swap;

  assign swap = (b < a);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/sort_ascending_5.sv
// Pipelined 5-input ascending sorter: 9 compare-swaps in 5 layers, one register bank per layer.
// Build option SORT5_HOLD_EN: stage banks load only with valid data, so outputs hold the last valid set.
module sort_ascending_5 #(
  parameter int DATA_WIDTH = sort_pkg::SORT5_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done_i,
  input  logic [DATA_WIDTH-1:0] S1,
  input  logic [DATA_WIDTH-1:0] S2,
  input  logic [DATA_WIDTH-1:0] S3,
  input  logic [DATA_WIDTH-1:0] S4,
  input  logic [DATA_WIDTH-1:0] S5,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] min,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] mid,
  output logic [DATA_WIDTH-1:0] out4,
  output logic [DATA_WIDTH-1:0] max
);
  import sort_pkg::*;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t in_v [5];
  word_t c1 [5], c2 [5], c3 [5], c4 [5], c5 [5];
  word_t r1 [5], r2 [5], r3 [5], r4 [5], r5 [5];
  word_t lo_w [9], hi_w [9];
  logic [SORT5_LATENCY-1:0] vld;

  always_comb begin
    in_v[0] = S1;
    in_v[1] = S2;
    in_v[2] = S3;
    in_v[3] = S4;
    in_v[4] = S5;
  end

  // Layer 1: (0,3)(1,4)
  cas_unit #(.W(DATA_WIDTH)) u_cas0 (.a(in_v[0]), .b(in_v[3]), .lo(lo_w[0]), .hi(hi_w[0]));
  cas_unit #(.W(DATA_WIDTH)) u_cas1 (.a(in_v[1]), .b(in_v[4]), .lo(lo_w[1]), .hi(hi_w[1]));
  // Layer 2: (0,2)(1,3)
  cas_unit #(.W(DATA_WIDTH)) u_cas2 (.a(r1[0]), .b(r1[2]), .lo(lo_w[2]), .hi(hi_w[2]));
  cas_unit #(.W(DATA_WIDTH)) u_cas3 (.a(r1[1]), .b(r1[3]), .lo(lo_w[3]), .hi(hi_w[3]));
  // Layer 3: (0,1)(2,4)
  cas_unit #(.W(DATA_WIDTH)) u_cas4 (.a(r2[0]), .b(r2[1]), .lo(lo_w[4]), .hi(hi_w[4]));
  cas_unit #(.W(DATA_WIDTH)) u_cas5 (.a(r2[2]), .b(r2[4]), .lo(lo_w[5]), .hi(hi_w[5]));
  // Layer 4: (1,2)(3,4)
  cas_unit #(.W(DATA_WIDTH)) u_cas6 (.a(r3[1]), .b(r3[2]), .lo(lo_w[6]), .hi(hi_w[6]));
  cas_unit #(.W(DATA_WIDTH)) u_cas7 (.a(r3[3]), .b(r3[4]), .lo(lo_w[7]), .hi(hi_w[7]));
  // Layer 5: (2,3)
  cas_unit #(.W(DATA_WIDTH)) u_cas8 (.a(r4[2]), .b(r4[3]), .lo(lo_w[8]), .hi(hi_w[8]));

  always_comb begin
    c1    = in_v;
    c1[0] = lo_w[0];
    c1[3] = hi_w[0];
    c1[1] = lo_w[1];
    c1[4] = hi_w[1];

    c2    = r1;
    c2[0] = lo_w[2];
    c2[2] = hi_w[2];
    c2[1] = lo_w[3];
    c2[3] = hi_w[3];

    c3    = r2;
    c3[0] = lo_w[4];
    c3[1] = hi_w[4];
    c3[2] = lo_w[5];
    c3[4] = hi_w[5];

    c4    = r3;
    c4[1] = lo_w[6];
    c4[2] = hi_w[6];
    c4[3] = lo_w[7];
    c4[4] = hi_w[7];

    c5    = r4;
    c5[2] = lo_w[8];
    c5[3] = hi_w[8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld <= {vld[SORT5_LATENCY-2:0], done_i};
    end
  end

  // vld[k] marks stage k+1 as holding a valid set; it gates the next bank's load when holding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        r1[i] <= '0;
        r2[i] <= '0;
        r3[i] <= '0;
        r4[i] <= '0;
        r5[i] <= '0;
      end
    end else begin
`ifdef SORT5_HOLD_EN
      if (done_i) r1 <= c1;
      if (vld[0]) r2 <= c2;
      if (vld[1]) r3 <= c3;
      if (vld[2]) r4 <= c4;
      if (vld[3]) r5 <= c5;
`else
      r1 <= c1;
      r2 <= c2;
      r3 <= c3;
      r4 <= c4;
      r5 <= c5;
`endif
    end
  end

  assign done_o = vld[SORT5_LATENCY-1];
  assign min    = r5[0];
  assign out2   = r5[1];
  assign mid    = r5[2];
  assign out4   = r5[3];
  assign max    = r5[4];

endmodule

// File: tb/tb_sort_ascending_5.sv
// Self-checking bench for sort_ascending_5: directed vectors plus a randomized run against a sort model.
module tb_sort_ascending_5;

  logic       clk = 1'b0;
  logic       rst;
  logic       done_i;
  logic [7:0] s1, s2, s3, s4, s5;
  logic       done_o;
  logic [7:0] o_min, o_out2, o_mid, o_out4, o_max;

  int tests = 0;
  int fails = 0;

  sort_ascending_5 #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .done_i(done_i),
    .S1(s1), .S2(s2), .S3(s3), .S4(s4), .S5(s5),
    .done_o(done_o),
    .min(o_min), .out2(o_out2), .mid(o_mid), .out4(o_out4), .max(o_max)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] outs();
    return {o_min, o_out2, o_mid, o_out4, o_max};
  endfunction

  function automatic logic [39:0] sort5(input logic [7:0] a, b, c, d, e);
    logic [7:0] x [5];
    logic [7:0] t;
    x[0] = a; x[1] = b; x[2] = c; x[3] = d; x[4] = e;
    for (int i = 1; i < 5; i++)
      for (int j = i; j > 0; j--)
        if (x[j] < x[j-1]) begin
          t = x[j]; x[j] = x[j-1]; x[j-1] = t;
        end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic drive(input logic v, input logic [7:0] a, b, c, d, e);
    done_i = v; s1 = a; s2 = b; s3 = c; s4 = d; s5 = e;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    tests++;
    if (done_o !== 1'b0) begin
      fails++; $display("FAIL reset_done_o: got %b exp 0", done_o);
    end
    tests++;
    if (outs() !== 40'h0) begin
      fails++; $display("FAIL reset_outputs: got %h exp %h", outs(), 40'h0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    @(negedge clk); drive(1'b1, 8'd12, 8'd24, 8'd35, 8'd9, 8'd18);
    @(negedge clk); drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (done_o !== 1'b0) begin
        fails++; $display("FAIL basic_early_done: cycle %0d got %b exp 0", i, done_o);
      end
      @(negedge clk);
    end
    tests++;
    if (done_o !== 1'b1) begin
      fails++; $display("FAIL basic_done: got %b exp 1", done_o);
    end
    tests++;
    if (outs() !== {8'd9, 8'd12, 8'd18, 8'd24, 8'd35}) begin
      fails++; $display("FAIL basic_data: got %h exp %h", outs(), {8'd9, 8'd12, 8'd18, 8'd24, 8'd35});
    end
    @(negedge clk);
    tests++;
    if (done_o !== 1'b0) begin
      fails++; $display("FAIL basic_single_pulse: got %b exp 0", done_o);
    end
  endtask

  // Two consecutive sets must emerge on consecutive cycles, first in first out.
  task automatic test_pair(input string name,
                           input logic [7:0] a0, a1, a2, a3, a4, input logic [39:0] ea,
                           input logic [7:0] b0, b1, b2, b3, b4, input logic [39:0] eb);
    @(negedge clk); drive(1'b1, a0, a1, a2, a3, a4);
    @(negedge clk); drive(1'b1, b0, b1, b2, b3, b4);
    @(negedge clk); drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    tests++;
    if (done_o !== 1'b1 || outs() !== ea) begin
      fails++; $display("FAIL %s_first: got done=%b %h exp done=1 %h", name, done_o, outs(), ea);
    end
    @(negedge clk);
    tests++;
    if (done_o !== 1'b1 || outs() !== eb) begin
      fails++; $display("FAIL %s_second: got done=%b %h exp done=1 %h", name, done_o, outs(), eb);
    end
    @(negedge clk);
    tests++;
    if (done_o !== 1'b0) begin
      fails++; $display("FAIL %s_end: got done=%b exp 0", name, done_o);
    end
  endtask

  task automatic test_back_to_back();
    test_pair("b2b",
              8'd12, 8'd24, 8'd35, 8'd9, 8'd18, {8'd9, 8'd12, 8'd18, 8'd24, 8'd35},
              8'd50, 8'd40, 8'd30, 8'd20, 8'd10, {8'd10, 8'd20, 8'd30, 8'd40, 8'd50});
  endtask

  task automatic test_ties();
    test_pair("ties_ext",
              8'd255, 8'd0, 8'd255, 8'd0, 8'd128, {8'd0, 8'd0, 8'd128, 8'd255, 8'd255},
              8'd7, 8'd7, 8'd7, 8'd7, 8'd7, {8'd7, 8'd7, 8'd7, 8'd7, 8'd7});
    test_pair("ties_mix",
              8'd3, 8'd3, 8'd1, 8'd3, 8'd1, {8'd1, 8'd1, 8'd3, 8'd3, 8'd3},
              8'd0, 8'd255, 8'd0, 8'd255, 8'd0, {8'd0, 8'd0, 8'd0, 8'd255, 8'd255});
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
    @(negedge clk); drive(1'b1, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5);
    @(negedge clk); drive(1'b1, 8'd40, 8'd10, 8'd30, 8'd20, 8'd50);
    @(negedge clk); drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (done_o !== 1'b0 || outs() !== 40'h0) begin
        fails++; $display("FAIL midrst_in_reset: got done=%b %h exp done=0 0", done_o, outs());
      end
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      tests++;
      if (done_o !== 1'b0) begin
        fails++; $display("FAIL midrst_flushed: got done=%b exp 0", done_o);
      end
    end
    drive(1'b1, 8'd100, 8'd3, 8'd77, 8'd3, 8'd200);
    @(negedge clk); drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (4) @(negedge clk);
    tests++;
    if (done_o !== 1'b1 || outs() !== {8'd3, 8'd3, 8'd77, 8'd100, 8'd200}) begin
      fails++; $display("FAIL midrst_new_set: got done=%b %h exp done=1 %h", done_o, outs(),
                        {8'd3, 8'd3, 8'd77, 8'd100, 8'd200});
    end
  endtask

  task automatic test_random();
    logic        mv [5];
    logic [39:0] md [5];
    logic        cur_v;
    logic [39:0] cur_d;
    logic [39:0] last;
    logic [7:0]  r [5];
    int          n_in, n_out;
    rst = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin mv[i] = 1'b0; md[i] = '0; end
    cur_v = 1'b0; cur_d = '0; last = '0; n_in = 0; n_out = 0;
    for (int cyc = 0; cyc < 1206; cyc++) begin
      @(negedge clk);
      for (int k = 4; k > 0; k--) begin mv[k] = mv[k-1]; md[k] = md[k-1]; end
      mv[0] = cur_v; md[0] = cur_d;
      if (done_o === 1'b1) n_out++;
      tests++;
      if (done_o !== mv[4]) begin
        fails++; $display("FAIL rand_done: cycle %0d got %b exp %b", cyc, done_o, mv[4]);
      end else if (mv[4]) begin
        tests++;
        if (outs() !== md[4]) begin
          fails++; $display("FAIL rand_data: cycle %0d got %h exp %h", cyc, outs(), md[4]);
        end
        last = md[4];
      end else begin
`ifdef SORT5_HOLD_EN
        tests++;
        if (outs() !== last) begin
          fails++; $display("FAIL rand_hold: cycle %0d got %h exp %h", cyc, outs(), last);
        end
`endif
      end
      for (int k = 0; k < 5; k++) r[k] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        r[1] = r[3];
        r[4] = (cyc % 2 == 0) ? 8'd0 : 8'd255;
      end
      cur_v = (cyc < 1200) && ($urandom_range(0, 2) != 0);
      cur_d = sort5(r[0], r[1], r[2], r[3], r[4]);
      if (cur_v) n_in++;
      drive(cur_v, r[0], r[1], r[2], r[3], r[4]);
    end
    tests++;
    if (n_out !== n_in || n_in == 0) begin
      fails++; $display("FAIL rand_count: got %0d done_o pulses exp %0d", n_out, n_in);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ties();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
